// File: rtl/merge_rr_pkg.sv
// Shared types and width helpers for the round-robin request merger.
// Request word layout, MSB to LSB: {valid, addr, wdata, wstrb}.
// Response word layout, MSB to LSB: {rdata, ready}.
package merge_rr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Width of one request word for the given address/data widths.
  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Width of one response word for the given data width.
  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

  // Width of a master index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/merge_rr_rr_pick.sv
// Combinational round-robin selector: returns the first eligible master
// scanning last+1, last+2, ... modulo N_MASTERS, optionally skipping one
// masked index (the current grantee, whose valid is still high on its
// completion cycle).
module rr_pick
  import merge_rr_pkg::*;
#(
  parameter int N_MASTERS = 2,
  localparam int IW = idx_width(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] i_valid,
  input  logic [IW-1:0]        i_last,
  input  logic                 i_mask_en,
  input  logic [IW-1:0]        i_mask,
  output logic                 o_found,
  output logic [IW-1:0]        o_index
);

  int w_dist;
  int w_best;

  // Pick the eligible master with the smallest rotational distance from last.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_dist  = 0;
    w_best  = N_MASTERS;
    for (int c = 0; c < N_MASTERS; c++) begin
      w_dist = (c - int'(i_last) - 1 + 2 * N_MASTERS) % N_MASTERS;
      if (i_valid[c] && !(i_mask_en && (c == int'(i_mask))) && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_found = 1'b1;
        o_index = IW'(c);
      end
    end
  end

endmodule

// File: rtl/merge_rr.sv
// Round-robin N-to-1 request merger. Holds the grant for a whole
// transaction, forwards the grantee's request to the single slave port and
// routes the slave response back to the grantee only. The request path is
// driven from registered state only; the response path is combinational.
module merge_rr
  import merge_rr_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  localparam int REQ_W    = req_width(ADDR_W, DATA_W),
  localparam int RESP_W   = resp_width(DATA_W)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS*REQ_W-1:0]  m_req,
  output logic [N_MASTERS*RESP_W-1:0] m_resp,
  output logic [REQ_W-1:0]            s_req,
  input  logic [RESP_W-1:0]           s_resp
);

  localparam int IW        = idx_width(N_MASTERS);
  localparam int VALID_POS = REQ_W - 1;
  localparam int READY_POS = 0;

  state_t                r_state;
  logic [IW-1:0]         r_grant;
  logic [IW-1:0]         r_last;

  logic [REQ_W-1:0]      w_req [N_MASTERS];
  logic [N_MASTERS-1:0]  w_valid;
  logic                  w_grant_valid;
  logic                  w_busy;
  logic [IW-1:0]         w_pick_last;
  logic                  w_found;
  logic [IW-1:0]         w_pick_idx;

  assign w_busy = (r_state == ST_BUSY);

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_slice
    assign w_req[g]   = m_req[g*REQ_W +: REQ_W];
    assign w_valid[g] = w_req[g][VALID_POS];
    assign m_resp[g*RESP_W +: RESP_W] = (w_busy && (r_grant == IW'(g))) ? s_resp : '0;
  end

  // On completion the scan starts after the current grantee, which becomes the new last.
  assign w_pick_last = w_busy ? r_grant : r_last;

  rr_pick #(
    .N_MASTERS (N_MASTERS)
  ) u_pick (
    .i_valid   (w_valid),
    .i_last    (w_pick_last),
    .i_mask_en (w_busy),
    .i_mask    (r_grant),
    .o_found   (w_found),
    .o_index   (w_pick_idx)
  );

  // Forward the grantee's request while busy and sample its valid for abort detection.
  always_comb begin
    s_req         = '0;
    w_grant_valid = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_grant == IW'(i)) begin
        w_grant_valid = w_valid[i];
        if (w_busy) begin
          s_req = w_req[i];
        end
      end
    end
  end

  // Arbitration state: grant on idle requests, re-arbitrate on completion, drop on abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= IW'(N_MASTERS - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick_idx;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_resp[READY_POS]) begin
            r_last <= r_grant;
            if (w_found) begin
              r_grant <= w_pick_idx;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (!w_grant_valid) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_merge_rr.sv
// Bench for merge_rr: a 4-master instance driven from a cycle table plus
// random traffic, and a 1-master instance driven by a short hand sequence
// plus random traffic. Random traffic is checked against an owner/last
// model built directly from the arbitration rules.
module tb_merge_rr;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int RQW = 1 + AW + DW + DW / 8;
  localparam int RSW = DW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [4*RQW-1:0]   m_req4;
  logic [4*RSW-1:0]   m_resp4;
  logic [RQW-1:0]     s_req4;
  logic [RSW-1:0]     s_resp4;
  logic [RQW-1:0]     m_req1;
  logic [RSW-1:0]     m_resp1;
  logic [RQW-1:0]     s_req1;
  logic [RSW-1:0]     s_resp1;

  merge_rr #(.N_MASTERS(4), .DATA_W(DW), .ADDR_W(AW)) u4 (
    .clk(clk), .rst(rst), .m_req(m_req4), .m_resp(m_resp4), .s_req(s_req4), .s_resp(s_resp4)
  );

  merge_rr #(.N_MASTERS(1), .DATA_W(DW), .ADDR_W(AW)) u1 (
    .clk(clk), .rst(rst), .m_req(m_req1), .m_resp(m_resp1), .s_req(s_req1), .s_resp(s_resp1)
  );

  // Masters 0..3 feed u4, master 4 feeds u1.
  logic        mv [5];
  logic [31:0] ma [5];
  logic [31:0] md [5];
  logic [3:0]  ms [5];
  logic        rdy4, rdy1;
  logic [31:0] rdat4, rdat1;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: owner index (-1 when nobody holds the port) and last winner.
  int own [2];
  int lst [2];

  typedef struct {
    logic       r;
    logic [3:0] v;
    logic       rdy;
    int         g;
  } vec_t;

  vec_t tbl [34];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic rdy, input int g);
    vec_t t;
    t.r = r; t.v = v; t.rdy = rdy; t.g = g;
    return t;
  endfunction

  function automatic logic [RQW-1:0] pack_req(input int i);
    return {mv[i], ma[i], md[i], ms[i]};
  endfunction

  function automatic logic [RQW-1:0] exp_sreq4(input int g);
    return (g < 0) ? '0 : pack_req(g);
  endfunction

  function automatic logic [4*RSW-1:0] exp_resp4(input int g);
    logic [4*RSW-1:0] r;
    r = '0;
    if (g >= 0) r[g*RSW +: RSW] = s_resp4;
    return r;
  endfunction

  // First valid master after 'from' in circular order, skipping 'excl'.
  function automatic int mpick(input int d, input int from, input int excl);
    int n, base, c;
    n    = (d == 0) ? 4 : 1;
    base = (d == 0) ? 0 : 4;
    for (int k = 1; k <= n; k++) begin
      c = (from + k) % n;
      if (mv[base + c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r);
    logic rd;
    int base;
    for (int d = 0; d < 2; d++) begin
      rd   = (d == 0) ? rdy4 : rdy1;
      base = (d == 0) ? 0 : 4;
      if (r) begin
        own[d] = -1;
        lst[d] = (d == 0) ? 3 : 0;
      end else if (own[d] < 0) begin
        own[d] = mpick(d, lst[d], -1);
      end else if (rd) begin
        lst[d] = own[d];
        own[d] = mpick(d, lst[d], own[d]);
      end else if (!mv[base + own[d]]) begin
        own[d] = -1;
      end
    end
  endtask

  task automatic check(input string nm, input logic [279:0] act, input logic [279:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic drive();
    m_req4  = {pack_req(3), pack_req(2), pack_req(1), pack_req(0)};
    m_req1  = pack_req(4);
    s_resp4 = {rdat4, rdy4};
    s_resp1 = {rdat1, rdy1};
  endtask

  // Inputs are already driven; look at outputs mid-cycle.
  task automatic settle();
    drive();
    @(negedge clk);
  endtask

  task automatic advance();
    model_step(rst);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(0, 4'b0010, 0, -1);
    tbl[1]  = mk(0, 4'b0010, 0,  1);
    tbl[2]  = mk(0, 4'b0010, 1,  1);
    tbl[3]  = mk(0, 4'b0000, 0, -1);
    tbl[4]  = mk(0, 4'b0000, 1, -1);
    tbl[5]  = mk(0, 4'b0010, 0, -1);
    tbl[6]  = mk(1, 4'b0010, 0,  1);
    tbl[7]  = mk(0, 4'b0011, 0, -1);
    tbl[8]  = mk(0, 4'b0011, 0,  0);
    tbl[9]  = mk(0, 4'b0011, 1,  0);
    tbl[10] = mk(0, 4'b0010, 1,  1);
    tbl[11] = mk(1, 4'b0000, 0, -1);
    tbl[12] = mk(0, 4'b1111, 0, -1);
    tbl[13] = mk(0, 4'b1111, 0,  0);
    tbl[14] = mk(0, 4'b1111, 1,  0);
    tbl[15] = mk(0, 4'b1111, 0,  1);
    tbl[16] = mk(0, 4'b1111, 1,  1);
    tbl[17] = mk(0, 4'b1111, 0,  2);
    tbl[18] = mk(0, 4'b1111, 1,  2);
    tbl[19] = mk(0, 4'b1111, 0,  3);
    tbl[20] = mk(0, 4'b1111, 1,  3);
    tbl[21] = mk(0, 4'b1111, 0,  0);
    tbl[22] = mk(0, 4'b0001, 1,  0);
    tbl[23] = mk(0, 4'b0100, 0, -1);
    tbl[24] = mk(0, 4'b0101, 1,  2);
    tbl[25] = mk(0, 4'b0101, 0,  0);
    tbl[26] = mk(0, 4'b0101, 1,  0);
    tbl[27] = mk(0, 4'b0100, 0,  2);
    tbl[28] = mk(0, 4'b0000, 0,  2);
    tbl[29] = mk(0, 4'b0000, 1, -1);
    tbl[30] = mk(0, 4'b1010, 0, -1);
    tbl[31] = mk(0, 4'b1010, 1,  1);
    tbl[32] = mk(0, 4'b1000, 1,  3);
    tbl[33] = mk(0, 4'b0000, 0, -1);

    ma[0] = 32'h0000_0000; md[0] = 32'hA0A0_A0A0; ms[0] = 4'h1;
    ma[1] = 32'h0000_0100; md[1] = 32'hDEAD_BEEF; ms[1] = 4'hF;
    ma[2] = 32'h0000_0200; md[2] = 32'hC2C2_C2C2; ms[2] = 4'h3;
    ma[3] = 32'h0000_0300; md[3] = 32'hD3D3_D3D3; ms[3] = 4'h7;
    ma[4] = 32'h0000_0040; md[4] = 32'h55AA_55AA; ms[4] = 4'h5;
    for (int i = 0; i < 5; i++) mv[i] = 1'b0;
    rdy4 = 1'b0; rdy1 = 1'b0;
    rdat4 = 32'h1234_5678; rdat1 = 32'hCAFE_F00D;
    own[0] = -1; own[1] = -1; lst[0] = 3; lst[1] = 0;

    rst = 1'b1;
    drive();
    @(posedge clk); #1;
    advance();
    rst = 1'b0;

    // Directed cycle table on the 4-master instance.
    for (int t = 0; t < 34; t++) begin
      rst  = tbl[t].r;
      rdy4 = tbl[t].rdy;
      for (int i = 0; i < 4; i++) mv[i] = tbl[t].v[i];
      settle();
      check($sformatf("tbl%0d_sreq", t), 280'(s_req4), 280'(exp_sreq4(tbl[t].g)));
      check($sformatf("tbl%0d_mresp", t), 280'(m_resp4), 280'(exp_resp4(tbl[t].g)));
      advance();
    end
    rst = 1'b0; rdy4 = 1'b0;
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;

    // Single-master instance: 1-cycle forward, response pass-through, idle gap.
    mv[4] = 1'b1; rdy1 = 1'b0;
    settle();
    check("n1_lat_sreq", 280'(s_req1), 280'(0));
    check("n1_lat_mresp", 280'(m_resp1), 280'(0));
    advance();
    rdy1 = 1'b1;
    settle();
    check("n1_fwd_sreq", 280'(s_req1), 280'({1'b1, 32'h40, 32'h55AA_55AA, 4'h5}));
    check("n1_fwd_mresp", 280'(m_resp1), 280'({32'hCAFE_F00D, 1'b1}));
    advance();
    rdy1 = 1'b0;
    settle();
    check("n1_gap_sreq", 280'(s_req1), 280'(0));
    advance();
    settle();
    check("n1_again_sreq", 280'(s_req1), 280'({1'b1, 32'h40, 32'h55AA_55AA, 4'h5}));
    advance();

    // Random traffic on both instances against the model.
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 5; i++) begin
        if (mv[i]) begin
          if ($urandom_range(3, 0) == 0) mv[i] = 1'b0;
        end else if ($urandom_range(1, 0) == 0) begin
          mv[i] = 1'b1;
          ma[i] = $urandom;
          md[i] = $urandom;
          ms[i] = 4'($urandom_range(15, 0));
        end
      end
      rdy4  = ($urandom_range(2, 0) == 0);
      rdy1  = ($urandom_range(2, 0) == 0);
      rdat4 = $urandom;
      rdat1 = $urandom;
      rst   = ($urandom_range(63, 0) == 0);
      settle();
      check("rnd4_sreq", 280'(s_req4), 280'(exp_sreq4(own[0])));
      check("rnd4_mresp", 280'(m_resp4), 280'(exp_resp4(own[0])));
      check("rnd1_sreq", 280'(s_req1), 280'((own[1] < 0) ? '0 : pack_req(4)));
      check("rnd1_mresp", 280'(m_resp1), 280'((own[1] < 0) ? '0 : s_resp1));
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
